// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Sequencing and HI/LO result stage around a combinational radix-4 Booth
//   product stage. It accepts a signed operand pair on a valid/ready
//   handshake and holds the operands on mcand_o/mplier_o for MUL_CYCLES
//   clocks. It then captures product_i into HI/LO and offers the result
//   downstream on a second valid/ready handshake.
//
//   Optional build macro: MUL_ZERO_BYPASS_EN. When it is defined, a zero
//   operand skips the settle window and yields a zero result immediately.
//
// Ports
//   clk        rising-edge clock
//   clear_n    asynchronous active-low reset (assert async, release sync)
//   in_valid   operand pair offered         in_ready  block can accept
//   a_in       multiplicand (signed)        b_in      multiplier (signed)
//   mcand_o    registered multiplicand      mplier_o  registered multiplier
//   product_i  signed 2*DATA_WIDTH product from the Booth stage
//   out_valid  HI/LO hold a new result      out_ready consumer accepts
//   hi_out     upper half of product        lo_out    lower half of product
//   busy       FSM not idle
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | in_ready=1, waiting for an operand pair
// WAIT    | operands driven to Booth stage, cnt counts down settle time
// DONE    | out_valid=1, HI/LO held until downstream accepts

module mul_seq_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int MUL_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    clear_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   a_in,
   input  logic [DATA_WIDTH-1:0]   b_in,
   output logic [DATA_WIDTH-1:0]   mcand_o,
   output logic [DATA_WIDTH-1:0]   mplier_o,
   input  logic [2*DATA_WIDTH-1:0] product_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   hi_out,
   output logic [DATA_WIDTH-1:0]   lo_out,
   output logic                    busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // The counter is loaded with MUL_CYCLES-1, so the capture happens on the
   // MUL_CYCLES-th edge after accept. The legal range 1..15 fits in 4 bits.
   localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

   logic [1:0] state;
   logic [3:0] cnt;
   logic       accept;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign accept    = in_valid && in_ready;

`ifdef MUL_ZERO_BYPASS_EN
   logic zero_op;
   assign zero_op = (a_in == '0) || (b_in == '0);
`endif

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         mcand_o  <= '0;
         mplier_o <= '0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  mcand_o  <= a_in;
                  mplier_o <= b_in;
                  cnt      <= CNT_LOAD;
`ifdef MUL_ZERO_BYPASS_EN
                  if (zero_op) begin
                     hi_out <= '0;
                     lo_out <= '0;
                     state  <= ST_DONE;
                  end else begin
                     state  <= ST_WAIT;
                  end
`else
                  state    <= ST_WAIT;
`endif
               end
            end
            ST_WAIT: begin
               // Operands have been stable since accept, so product_i has
               // settled by the time cnt reaches zero.
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  {hi_out, lo_out} <= product_i;
                  state            <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
